// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
// The state enum is also used by benches and checkers that watch dbg_state.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  localparam int MULT_W_DEFAULT = 8;

endpackage

// File: rtl/mult_sign_conv.sv
// Operand conditioning: yields the unsigned magnitude of a value and its raw MSB.
// In signed mode the most negative value maps to 2^(WIDTH-1), which still fits in WIDTH bits.
module mult_sign_conv
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W_DEFAULT
) (
  input  logic [WIDTH-1:0] value,
  input  logic             sign_mode,
  output logic [WIDTH-1:0] mag,
  output logic             msb
);

  assign msb = value[WIDTH-1];
  assign mag = (sign_mode && msb) ? -value : value;

endmodule

// File: rtl/multiplier_seq_nxn.sv
// Iterative WIDTH x WIDTH shift-add multiplier, signed or unsigned per operation.
// One multiplier bit per cycle on operand magnitudes; the sign is applied once at the end.
module multiplier_seq_nxn
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W_DEFAULT
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [WIDTH-1:0]   In_1,
  input  logic [WIDTH-1:0]   In_2,
  input  logic               Sign,
  input  logic               In_Valid,
  output logic               In_Ready,
  output logic [2*WIDTH-1:0] Result,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [1:0]         dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // In_Ready and Out_Valid are flops; the producer holds In_Valid until accepted and
  // Result stays stable while Out_Valid=1 and Out_Ready=0.

  mult_state_t state, state_nxt;

  logic [WIDTH-1:0]   mag_1, mag_2;
  logic               msb_1, msb_2;
  logic [WIDTH-1:0]   mcand_q, mplier_q;
  logic [2*WIDTH-1:0] acc_q, addend, result_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic               in_ready_q, out_valid_q;
  logic               accept, release_out, last_bit;

  mult_sign_conv #(.WIDTH(WIDTH)) u_conv_1 (
    .value     (In_1),
    .sign_mode (Sign),
    .mag       (mag_1),
    .msb       (msb_1)
  );

  mult_sign_conv #(.WIDTH(WIDTH)) u_conv_2 (
    .value     (In_2),
    .sign_mode (Sign),
    .mag       (mag_2),
    .msb       (msb_2)
  );

  assign accept      = (state == IDLE) && In_Valid;
  assign release_out = (state == DONE) && Out_Ready;
  assign last_bit    = (cnt_q == LAST_CNT);
  assign addend      = {{WIDTH{1'b0}}, mcand_q} << cnt_q;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (In_Valid) state_nxt = CALC;
      CALC:    if (last_bit) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (Out_Ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (In_Valid) begin
            mcand_q  <= mag_1;
            mplier_q <= mag_2;
            neg_q    <= Sign & (msb_1 ^ msb_2);
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        CALC: begin
          if (mplier_q[0]) acc_q <= acc_q + addend;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        // Negating a zero accumulator yields zero, so no special case is needed.
        FIX:     result_q <= neg_q ? -acc_q : acc_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      if (accept)           in_ready_q <= 1'b0;
      else if (release_out) in_ready_q <= 1'b1;

      if (state == FIX)     out_valid_q <= 1'b1;
      else if (release_out) out_valid_q <= 1'b0;
    end
  end

  assign In_Ready  = in_ready_q;
  assign Out_Valid = out_valid_q;
  assign Result    = result_q;
  assign dbg_state = state;

endmodule

// File: doc/multiplier_seq_nxn.md
Name: multiplier_seq_nxn

Overview:
Parametrised iterative shift-add multiplier. Successor to the fixed 4x4 combinational multiplier.
- Operand width set by WIDTH; per-operation signed/unsigned mode.
- Registered valid/ready handshakes on input and output.
- Sits in the NPU MAC datapath where area matters more than throughput, and feeds the accumulator stage.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32); Result is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  synchronous active-low reset
In_1  input  WIDTH  multiplicand
In_2  input  WIDTH  multiplier
Sign  input  1  1 = two's-complement operands, 0 = unsigned
In_Valid  input  1  operands valid
In_Ready  output  1  block can accept operands
Result  output  2*WIDTH  product
Out_Valid  output  1  Result valid
Out_Ready  input  1  consumer accepts Result

Behaviour:
- One clock, Clk. Reset is synchronous and active-low on Rst_n. Rst_n sampled low at a rising edge forces:
  - state IDLE, In_Ready=1, Out_Valid=0, Result=0
  - all internal registers cleared.
- Reset asserted mid-operation aborts it with no output. The in-flight operation is lost.
- FSM states and transitions:
  - IDLE: In_Ready=1. On an edge with In_Valid=1:
    - latch Sign;
    - latch |In_1| and |In_2| into the multiplicand/multiplier registers (magnitude when Sign=1, raw value when Sign=0);
    - latch neg = Sign & (In_1[MSB] ^ In_2[MSB]);
    - clear the accumulator; cnt=0; go to CALC.
  - CALC: In_Ready=0. Each edge:
    - if multiplier LSB=1, accumulator += multiplicand << cnt;
    - shift multiplier right 1; cnt++.
    - When cnt reaches WIDTH-1 on that edge (the last bit processed), go to FIX.
    - Always exactly WIDTH cycles. No early termination on a zero multiplier.
  - FIX: one edge.
    - Result <= neg ? -accumulator : accumulator (2*WIDTH two's complement).
    - Out_Valid <= 1; go to DONE.
  - DONE: Out_Valid=1; Result held stable while Out_Ready=0. On an edge with Out_Ready=1: Out_Valid <= 0, go to IDLE.
- Timing and throughput:
  - Latency: Out_Valid rises on the (WIDTH+1)th edge after the accepting edge.
  - No input/output overlap. In_Ready returns one cycle after output acceptance.
  - Minimum initiation interval is WIDTH+3 cycles.
- Signed edge cases:
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1). It fits in WIDTH unsigned bits; the conversion must not overflow.
  - Signed (-2^(W-1))*(-2^(W-1)) = 2^(2W-2), which is representable.
  - Zero product with neg=1 yields 0 (negating 0 gives 0).
- Inputs In_1, In_2 and Sign are ignored outside the accepting edge. Changes during CALC, FIX or DONE have no effect.
- Result is don't-care-stable (holds its last value) while Out_Valid=0. It is only reset to 0 by Rst_n.
- In_Valid high while In_Ready=0 is ignored. The producer must hold its request until In_Ready.

Decomposition:
- Shared package mult_pkg:
  - state enum mult_state_t {IDLE, CALC, FIX, DONE}, 2-bit encoding;
  - default width constant MULT_W_DEFAULT=8.
- One sub-module, mult_sign_conv. Combinational: (value, sign_mode) -> magnitude and MSB flag. Instantiated once per operand.
- FSM, counter and datapath stay in multiplier_seq_nxn.

Test Plan:
1. WIDTH=8, Sign=0, In_1=255, In_2=255, Out_Ready=1 -> Result=0xFE01. Out_Valid rises exactly 9 edges after acceptance; In_Ready=0 throughout.
2. WIDTH=8, Sign=1, In_1=0x80 (-128), In_2=0x80 -> Result=0x4000. Then In_1=0xFD (-3), In_2=0x05 -> Result=0xFFF1 (-15). Then In_1=0x00, In_2=0x80 -> Result=0x0000.
3. Same bit pattern in both modes: In_1=0xFF, In_2=0x02:
   - Sign=0 -> Result=0x01FE;
   - Sign=1 -> Result=0xFFFE.
4. Backpressure: hold Out_Ready=0 for 5 cycles after Out_Valid -> Result and Out_Valid stable. In_Ready stays 0 even with In_Valid=1 and new operands. Raise Out_Ready -> Out_Valid falls next edge, In_Ready=1.
5. Reset mid-CALC: accept 7*9, drive Rst_n=0 for one edge at cnt=3 -> Out_Valid=0, Result=0, In_Ready=1. The next op 12*12 (Sign=0) returns 0x0090 with no residue from the aborted op.
6. Operand change during CALC: accept 3*4 with Sign=0, then change In_1, In_2 and Sign every cycle -> Result=0x000C. Also run back-to-back ops with Out_Ready tied 1 -> one result per WIDTH+3 cycles.
